// File: rtl/perm_line_feeder.sv
// -----------------------------------------------------------------------------
// perm_line_feeder
//
// Input staging buffer that sits directly upstream of the permutation stage.
// It collects DEPTH state lines (one 5x5 slice each) from a valid/ready
// stream and then issues a one-cycle start pulse to the permutation stage.
// While the permutation runs, it serves lines combinationally, addressed by
// the permutation stage's own line counter. When the permutation reports
// done, the feeder releases the buffer and starts refilling it.
//
// Optional feature (macro LINE_PARITY_EN):
//   Adds in_parity / parity_err. Each accepted line is checked against the
//   even parity of its payload. A mismatch sets a sticky error flag, which
//   clears on reset or when the buffer is released after perm_done.
//
// Ports:
//   clk             in   system clock, rising edge
//   rst             in   asynchronous reset, active low
//   in_valid        in   upstream line valid
//   in_ready        out  feeder can accept a line (registered)
//   in_data         in   line payload, stored in arrival order
//   perm_start      out  one-cycle start pulse to the permutation stage
//   perm_cnt_value  in   line index requested by the permutation stage
//   perm_line_in    out  buffered line at perm_cnt_value (combinational)
//   perm_done       in   permutation finished
//   busy            out  permutation in flight
//   lines_loaded    out  lines accepted in the current fill (0..DEPTH)
//   in_parity       in   (LINE_PARITY_EN) expected even parity of in_data
//   parity_err      out  (LINE_PARITY_EN) sticky parity mismatch flag
// -----------------------------------------------------------------------------
module perm_line_feeder #(
    parameter int LINE_W = 25,
    parameter int DEPTH  = 64,
    parameter int CNT_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LINE_W-1:0] in_data,
    output logic              perm_start,
    input  logic [CNT_W-1:0]  perm_cnt_value,
    output logic [LINE_W-1:0] perm_line_in,
    input  logic              perm_done,
    output logic              busy,
    output logic [CNT_W-1:0]  lines_loaded
`ifdef LINE_PARITY_EN
    ,
    input  logic              in_parity,
    output logic              parity_err
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_KICK = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                w_accept;
    logic                w_release;
    logic                r_in_ready;
    logic                r_perm_start;
    logic                r_busy;
    logic [CNT_W-1:0]    r_lines_loaded;
    logic [CNT_W-1:0]    r_wr_ptr;
    logic [LINE_W-1:0]   r_mem [DEPTH];
    logic [LINE_W-1:0]   w_line;

    // Even parity of one line payload.
    function automatic logic even_parity(input logic [LINE_W-1:0] d);
        return ^d;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic plus accept / release strobes.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            ST_FILL: begin
                // The saturation guard keeps a 65th line out even if
                // in_ready were ever stale for a cycle.
                w_accept = in_valid && r_in_ready &&
                           (r_lines_loaded != CNT_W'(DEPTH));
                if (w_accept && (r_lines_loaded == CNT_W'(DEPTH - 1))) begin
                    w_next_state = ST_KICK;
                end else begin
                    w_next_state = ST_FILL;
                end
            end
            ST_KICK: begin
                w_next_state = ST_RUN;
            end
            ST_RUN: begin
                if (perm_done) begin
                    w_release    = 1'b1;
                    w_next_state = ST_FILL;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            default: begin
                w_next_state = ST_FILL;
            end
        endcase
    end

    // Registered handshake/control outputs. These follow the state being
    // entered, so in_ready and perm_start line up with FILL and KICK.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_ready   <= 1'b0;
            r_perm_start <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_in_ready   <= (w_next_state == ST_FILL);
            r_perm_start <= (w_next_state == ST_KICK);
            if (r_state == ST_KICK) begin
                r_busy <= 1'b1;
            end else if (w_release) begin
                r_busy <= 1'b0;
            end else begin
                r_busy <= r_busy;
            end
        end
    end

    // Fill counters. wr_ptr never wraps because release clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lines_loaded <= '0;
            r_wr_ptr       <= '0;
        end else if (w_release) begin
            r_lines_loaded <= '0;
            r_wr_ptr       <= '0;
        end else if (w_accept) begin
            r_lines_loaded <= r_lines_loaded + CNT_W'(1);
            r_wr_ptr       <= r_wr_ptr + CNT_W'(1);
        end else begin
            r_lines_loaded <= r_lines_loaded;
            r_wr_ptr       <= r_wr_ptr;
        end
    end

    // Line buffer. Old contents stay readable until overwritten.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_accept) begin
            r_mem[r_wr_ptr[AW-1:0]] <= in_data;
        end else begin
            r_mem <= r_mem;
        end
    end

    // Zero-latency read port; indices beyond the buffer return zero.
    always_comb begin
        w_line = '0;
        if (perm_cnt_value < CNT_W'(DEPTH)) begin
            w_line = r_mem[perm_cnt_value[AW-1:0]];
        end else begin
            w_line = '0;
        end
    end

`ifdef LINE_PARITY_EN
    logic r_parity_err;

    // Sticky parity error, cleared when the buffer is released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_parity_err <= 1'b0;
        end else if (w_release) begin
            r_parity_err <= 1'b0;
        end else if (w_accept && (in_parity != even_parity(in_data))) begin
            r_parity_err <= 1'b1;
        end else begin
            r_parity_err <= r_parity_err;
        end
    end

    assign parity_err = r_parity_err;
`endif

    assign in_ready     = r_in_ready;
    assign perm_start   = r_perm_start;
    assign busy         = r_busy;
    assign lines_loaded = r_lines_loaded;
    assign perm_line_in = w_line;

endmodule
